// File: rtl/clken_gen.sv
// Fractional clock-enable generator: NCH accumulators on refclk, ce is a registered 1-cycle pulse per rollover.
// Latency compare->ce is 1 cycle; cfg writes stall (cfg_ready=0) whenever the block is not LOCKED.
module clken_gen #(
  parameter int NCH         = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NCH*ACC_W-1:0] DEF_NUM = {24'd6, 24'd12, 24'd3, 24'd12},
  parameter logic [NCH*ACC_W-1:0] DEF_DEN = {24'd335, 24'd335, 24'd25, 24'd25},
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_num,
  input  logic [ACC_W-1:0] cfg_den,
  input  logic             apply,
  output logic [NCH-1:0]   ce,
  output logic             locked,
  output logic [NCH-1:0]   cfg_err
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [ACC_W-1:0] r_sh_num  [NCH];
  logic [ACC_W-1:0] r_sh_den  [NCH];
  logic [ACC_W-1:0] r_act_num [NCH];
  logic [ACC_W-1:0] r_act_den [NCH];
  logic [ACC_W-1:0] r_acc     [NCH];
  logic [NCH-1:0]   r_ce;

  logic [ACC_W-1:0] w_sh_num_nxt [NCH];
  logic [ACC_W-1:0] w_sh_den_nxt [NCH];
  logic [ACC_W:0]   w_sum        [NCH];
  logic [ACC_W-1:0] w_diff       [NCH];
  logic             w_accept;
  logic             w_apply;
  logic             w_run;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SETTLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    locked      = 1'b0;
    case (r_state)
      ST_SETTLE: if (r_cnt == CNT_LAST) w_state_nxt = ST_LOCKED;
      ST_LOCKED: begin
        cfg_ready = 1'b1;
        locked    = 1'b1;
        if (apply) w_state_nxt = ST_APPLY;
      end
      ST_APPLY:  w_state_nxt = ST_SETTLE;
      default:   w_state_nxt = ST_SETTLE;
    endcase
  end

  assign w_accept = cfg_valid & cfg_ready;
  assign w_apply  = locked & apply;
  assign w_run    = locked & ~apply;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) r_cnt <= r_cnt + CNT_W'(1);
    else r_cnt <= '0;
  end

  // Out-of-range channel numbers match no entry, so such writes are silently dropped.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_sh_num_nxt[i] = r_sh_num[i];
      w_sh_den_nxt[i] = r_sh_den[i];
      if (w_accept && cfg_ch == CH_W'(i)) begin
        w_sh_num_nxt[i] = cfg_num;
        w_sh_den_nxt[i] = cfg_den;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cfg_err[i] = (r_act_num[i] == '0) || (r_act_den[i] == '0) || (r_act_num[i] > r_act_den[i]);
      w_sum[i]   = {1'b0, r_acc[i]} + {1'b0, r_act_num[i]};
      w_diff[i]  = ACC_W'(w_sum[i] - {1'b0, r_act_den[i]});
    end
  end

  // Apply copies the post-write shadow so a same-cycle write is part of the transfer.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_sh_num[i]  <= DEF_NUM[i*ACC_W +: ACC_W];
        r_sh_den[i]  <= DEF_DEN[i*ACC_W +: ACC_W];
        r_act_num[i] <= DEF_NUM[i*ACC_W +: ACC_W];
        r_act_den[i] <= DEF_DEN[i*ACC_W +: ACC_W];
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_sh_num[i] <= w_sh_num_nxt[i];
        r_sh_den[i] <= w_sh_den_nxt[i];
        if (w_apply) begin
          r_act_num[i] <= w_sh_num_nxt[i];
          r_act_den[i] <= w_sh_den_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
      r_ce <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_run && !cfg_err[i]) begin
          if (w_sum[i] >= {1'b0, r_act_den[i]}) begin
            r_acc[i] <= w_diff[i];
            r_ce[i]  <= 1'b1;
          end else begin
            r_acc[i] <= w_sum[i][ACC_W-1:0];
            r_ce[i]  <= 1'b0;
          end
        end else begin
          r_acc[i] <= '0;
          r_ce[i]  <= 1'b0;
        end
      end
    end
  end

  assign ce = r_ce;

endmodule

// File: tb/tb_clken_gen.sv
// Bench for clken_gen: scoreboard of per-cycle expected outputs from a ratio-arithmetic model.
`timescale 1ns/1ps
module tb_clken_gen;
  localparam int NCH   = 4;
  localparam int ACC_W = 24;
  localparam int LOCK  = 16;
  localparam int CH_W  = 2;

  logic             refclk = 1'b0;
  logic             rst_n  = 1'b1;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic             apply;
  logic [NCH-1:0]   ce;
  logic             locked;
  logic [NCH-1:0]   cfg_err;

  always #5 refclk = ~refclk;

  clken_gen #(.NCH(NCH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK)) dut (
    .refclk(refclk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .apply(apply),
    .ce(ce), .locked(locked), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic           lk;
    logic           rdy;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] err;
  } obs_t;

  obs_t sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   cnt [NCH];

  // Reference model: ratios plus "edges until lock" and "cycles since lock".
  longint m_sh_num [NCH];
  longint m_sh_den [NCH];
  longint m_num    [NCH];
  longint m_den    [NCH];
  int     m_left;
  longint m_k;

  function automatic longint def_num(int i);
    case (i) 0: return 12; 1: return 3; 2: return 12; default: return 6; endcase
  endfunction

  function automatic longint def_den(int i);
    return (i < 2) ? 64'd25 : 64'd335;
  endfunction

  function automatic bit legal(longint n, longint d);
    return (n != 0) && (d != 0) && (n <= d);
  endfunction

  // A pulse lands on cycle k whenever floor(k*n/d) steps up: n pulses per d cycles, evenly spread.
  function automatic bit pulse(longint k, longint n, longint d);
    if (k < 1) return 1'b0;
    return ((k * n) / d) != (((k - 1) * n) / d);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_sh_num[i] = def_num(i); m_sh_den[i] = def_den(i);
      m_num[i]    = def_num(i); m_den[i]    = def_den(i);
    end
    m_left = LOCK;
    m_k    = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (m_left == 0) begin
      if (cfg_valid) begin
        m_sh_num[cfg_ch] = cfg_num;
        m_sh_den[cfg_ch] = cfg_den;
      end
      if (apply) begin
        for (int i = 0; i < NCH; i++) begin
          m_num[i] = m_sh_num[i];
          m_den[i] = m_sh_den[i];
        end
        m_left = LOCK + 1;
      end else m_k++;
    end else begin
      m_left--;
      if (m_left == 0) m_k = 0;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.lk  = (m_left == 0);
    o.rdy = o.lk;
    for (int i = 0; i < NCH; i++) begin
      o.err[i] = !legal(m_num[i], m_den[i]);
      o.ce[i]  = o.lk && legal(m_num[i], m_den[i]) && pulse(m_k, m_num[i], m_den[i]);
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
    model_edge();
    sb.push_back(model_obs());
  endtask

  task automatic check(string name, longint got, longint req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (locked !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
  endtask

  task automatic run_count(int n);
    repeat (n) begin
      tick();
      for (int i = 0; i < NCH; i++) cnt[i] += int'(ce[i]);
    end
  endtask

  task automatic write_cfg(int ch, int num, int den, bit ap);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch);
    cfg_num = ACC_W'(num); cfg_den = ACC_W'(den); apply = ap;
    tick();
    cfg_valid = 1'b0; apply = 1'b0;
  endtask

  task automatic do_apply();
    apply = 1'b1;
    tick();
    apply = 1'b0;
  endtask

  // Monitor: one scoreboard entry per refclk cycle, compared mid-cycle.
  initial begin
    obs_t exp_o;
    obs_t got;
    forever begin
      @(negedge refclk);
      if (sb.size() > 0) begin
        exp_o = sb.pop_front();
        got   = {locked, cfg_ready, ce, cfg_err};
        checks++;
        if (got !== exp_o) begin
          failures++;
          $display("FAIL cycle_obs t=%0t got lk=%b rdy=%b ce=%b err=%b required lk=%b rdy=%b ce=%b err=%b",
                   $time, got.lk, got.rdy, got.ce, got.err, exp_o.lk, exp_o.rdy, exp_o.ce, exp_o.err);
        end
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] pat;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; apply = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    wait_lock(n);
    check("lock_after_reset", n, 16);
    clear_cnt();
    run_count(25);
    check("def_ch0_per25", cnt[0], 12);
    check("def_ch1_per25", cnt[1], 3);
    run_count(310);
    check("def_ch2_per335", cnt[2], 12);
    check("def_ch3_per335", cnt[3], 6);

    write_cfg(0, 1, 2, 1'b0);
    do_apply();
    wait_lock(n);
    check("lock_after_apply", n, 17);
    pat[0] = ce[0];
    for (int j = 1; j < 6; j++) begin
      tick();
      pat[j] = ce[0];
    end
    check("ch0_half_pattern", pat, 6'b010100);

    write_cfg(1, 5, 5, 1'b1);
    wait_lock(n);
    check("lock_after_bypass", n, 17);
    clear_cnt();
    run_count(10);
    check("ch1_full_rate", cnt[1], 10);

    write_cfg(2, 0, 7, 1'b1);
    wait_lock(n);
    check("ch2_err_num0", cfg_err[2], 1);
    clear_cnt();
    run_count(30);
    check("ch2_silent_num0", cnt[2], 0);
    check("ch0_unaffected", cnt[0], 15);
    check("ch1_unaffected", cnt[1], 30);

    write_cfg(2, 8, 7, 1'b1);
    wait_lock(n);
    check("ch2_err_gt", cfg_err[2], 1);
    clear_cnt();
    run_count(30);
    check("ch2_silent_gt", cnt[2], 0);

    write_cfg(2, 1, 7, 1'b1);
    wait_lock(n);
    check("ch2_err_clear", cfg_err[2], 0);
    clear_cnt();
    run_count(70);
    check("ch2_one_in_seven", cnt[2], 10);

    // Writes held only during settle must be ignored; held into LOCKED they land.
    write_cfg(3, 1, 4, 1'b1);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_num = 24'd3; cfg_den = 24'd4;
    repeat (5) tick();
    cfg_valid = 1'b0;
    wait_lock(n);
    clear_cnt();
    run_count(40);
    check("ch3_settle_write_dropped", cnt[3], 10);
    do_apply();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_num = 24'd3; cfg_den = 24'd5;
    wait_lock(n);
    check("ready_first_locked", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    do_apply();
    wait_lock(n);
    clear_cnt();
    run_count(50);
    check("ch0_held_write_applied", cnt[0], 30);

    repeat (1200) begin
      cfg_valid = ($urandom % 3) == 0;
      cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
      cfg_num   = ACC_W'($urandom_range(0, 10));
      cfg_den   = ACC_W'($urandom_range(0, 10));
      apply     = ($urandom % 80) == 0;
      tick();
    end
    cfg_valid = 1'b0; apply = 1'b0;

    wait_lock(n);
    repeat (7) tick();
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked_drop", locked, 0);
    check("async_ce_drop", ce, 0);
    check("async_ready_drop", cfg_ready, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_lock(n);
    check("lock_after_midreset", n, 16);
    clear_cnt();
    run_count(25);
    check("restored_ch0_per25", cnt[0], 12);
    check("restored_ch1_per25", cnt[1], 3);

    @(negedge refclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
